line_step_engine: RTL and testbench
===================================

// Module: line_step_engine
// PURPOSE
//  Bresenham stepping stage of the line-drawing core. Accepts one line (two signed endpoints)
//  per handshake, runs setup (deltas, octant, initial error = major_delta/2 via divide_by_two),
//  then emits one pixel coordinate per cycle toward the pixel writer under valid/ready backpressure.
// PARAMETERS
//  WIDTH     13   signed 2's-complement coordinate width (in and out)
//  SCREEN_W  640  clip width; used only with PIXEL_CLIP_EN
//  SCREEN_H  480  clip height; used only with PIXEL_CLIP_EN
// PORTS
//  clk         in   1      clock; all state changes on rising edge
//  rst         in   1      synchronous, active-high reset
//  line_valid  in   1      endpoint set presented
//  line_ready  out  1      engine can accept a line (high only in IDLE)
//  x0,y0       in   WIDTH  start point, signed
//  x1,y1       in   WIDTH  end point, signed
//  pix_valid   out  1      pix_x/pix_y hold a pixel
//  pix_ready   in   1      downstream accepts pixel
//  pix_x,pix_y out  WIDTH  pixel coordinate, signed
//  pix_last    out  1      qualifies final emitted pixel of the line
//  busy        out  1      high from line accept until done
//  done        out  1      one-cycle pulse when line finished
// BEHAVIOUR
//  Reset: line_ready=1 (enters IDLE), pix_valid=0, pix_last=0, busy=0, done=0, pix_x=pix_y=0.
//  FSM IDLE -> SETUP on line_valid&&line_ready (endpoints registered); SETUP -> STEP after 1 cycle;
//   STEP -> DONE after final pixel handshake; DONE -> IDLE after 1 cycle (done=1 in DONE).
//  Latency: accept at cycle N, first pix_valid at N+2. Throughput 1 pixel/cycle with pix_ready=1.
//  Setup: dx=x1-x0, dy=y1-y0 at WIDTH+1 bits (no overflow); sx/sy = sign (+1/-1; +1 when zero);
//   adx=|dx|, ady=|dy|; steep = ady>adx; major=max, minor=min; err=major>>>1 (arithmetic shift).
//  Step (on each pix handshake): err'=err-minor; if err'<0: minor axis += its step, err'+=major;
//   major axis always += its step. Walk always from (x0,y0) to (x1,y1); no endpoint swap.
//  Pixel count = major+1; pix_last with pixel equal to (x1,y1). Degenerate line (x0,y0)==(x1,y1):
//   exactly one pixel, pix_last=1.
//  Backpressure: while pix_valid&&!pix_ready, pix_x/pix_y/pix_last and internal state held stable.
//  line_valid during SETUP/STEP/DONE ignored (line_ready=0); no input is lost or queued.
//  rst mid-line: next cycle IDLE, pix_valid=0, no done pulse; partial line abandoned.
//  Error register width WIDTH+2 signed; never overflows for legal WIDTH-bit endpoints.
// CONFIGURATION
//  PIXEL_CLIP_EN defined: pixels with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H are not presented
//   (pix_valid=0); the stepper advances through them at 1 step/cycle without waiting on pix_ready.
//   pix_last only if (x1,y1) is on-screen; done pulses regardless.
//  Not defined: every stepped pixel presented; SCREEN_W/SCREEN_H unused.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, SETUP, STEP, DONE), coordinate/error widths.
//  Sub-module: line_setup (combinational: deltas, abs, signs, steep, major/minor) feeding SETUP
//   register; initial error through an instance of divide_by_two at WIDTH+1.
// TESTING
//  (0,0)->(4,2), pix_ready=1 -> (0,0),(1,0),(2,1),(3,1),(4,2) on consecutive cycles, pix_last on
//   (4,2), done 1 cycle later; first pixel 2 cycles after accept.
//  (3,5)->(1,0) steep, negative -> (3,5),(3,4),(2,3),(2,2),(1,1),(1,0); pix_last on (1,0).
//  (7,7)->(7,7) -> single pixel (7,7) with pix_last=1, then done pulse.
//  (0,0)->(4,2), pix_ready=0 for 3 cycles while (2,1) presented -> (2,1) held, sequence unchanged.
//  rst=1 during pixel 3 of (0,0)->(10,0) -> pix_valid=0 next cycle, line_ready=1, no done pulse.
//  PIXEL_CLIP_EN, (-2,0)->(2,0) -> only (0,0),(1,0),(2,0) valid, pix_last on (2,0), done pulses.

Source files
------------

// File: rtl/line_step_engine_pkg.sv
// Shared definitions for the line-drawing stepper: FSM encoding and the
// width rules for coordinates, deltas and the Bresenham error term.
package line_step_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int COORD_W_DEFAULT = 13;

    // A difference of two WIDTH-bit signed values needs one extra bit.
    function automatic int delta_width(input int coord_w);
        return coord_w + 1;
    endfunction

    // The error term swings between -minor and +major, so one more bit on top.
    function automatic int err_width(input int coord_w);
        return coord_w + 2;
    endfunction

endpackage

// File: rtl/divide_by_two.sv
// Signed halving by arithmetic shift right (rounds toward minus infinity).
module divide_by_two #(
    parameter int W = 14
) (
    input  logic signed [W-1:0] value,
    output logic signed [W-1:0] half
);

    assign half = value >>> 1;

endmodule

// File: rtl/line_setup.sv
// Combinational line setup: signed deltas, step directions, octant (steep)
// and the major/minor axis lengths for the Bresenham walk.
module line_setup
    import line_step_engine_pkg::*;
#(
    parameter int WIDTH = COORD_W_DEFAULT
) (
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic             sx_neg,
    output logic             sy_neg,
    output logic             steep,
    output logic [WIDTH:0]   major,
    output logic [WIDTH:0]   minor
);

    localparam int DW = delta_width(WIDTH);

    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic        [DW-1:0] adx;
    logic        [DW-1:0] ady;

    // A zero delta counts as a positive direction.
    always_comb begin
        dx     = $signed({x1[WIDTH-1], x1}) - $signed({x0[WIDTH-1], x0});
        dy     = $signed({y1[WIDTH-1], y1}) - $signed({y0[WIDTH-1], y0});
        sx_neg = dx[DW-1];
        sy_neg = dy[DW-1];
        adx    = sx_neg ? -dx : dx;
        ady    = sy_neg ? -dy : dy;
        steep  = ady > adx;
        major  = steep ? ady : adx;
        minor  = steep ? adx : ady;
    end

endmodule

// File: rtl/line_step_engine.sv
// Bresenham stepping stage: accepts one line per handshake and emits one pixel
// per cycle under valid/ready. Optional macro PIXEL_CLIP_EN hides off-screen pixels.
module line_step_engine
    import line_step_engine_pkg::*;
#(
    parameter int WIDTH    = COORD_W_DEFAULT,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_valid,
    output logic             line_ready,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [WIDTH-1:0] pix_x,
    output logic [WIDTH-1:0] pix_y,
    output logic             pix_last,
    output logic             busy,
    output logic             done
);

    localparam int DW = delta_width(WIDTH);
    localparam int EW = err_width(WIDTH);

    // The clip window must be a positive size that fits a signed coordinate.
    if (SCREEN_W < 1 || SCREEN_H < 1 ||
        SCREEN_W >= 2**(WIDTH-1) || SCREEN_H >= 2**(WIDTH-1)) begin : g_bad_clip
        $error("line_step_engine: clip window does not fit WIDTH");
    end

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] ex0, ey0, ex1, ey1;
    logic signed [WIDTH-1:0] cur_x, cur_y;

    logic          set_sx_neg, set_sy_neg, set_steep;
    logic [DW-1:0] set_major, set_minor;
    logic signed [DW-1:0] half_major;

    logic          sx_neg_q, sy_neg_q, steep_q;
    logic [DW-1:0] major_q, minor_q;
    logic [DW-1:0] remain;
    logic signed [EW-1:0] err, err_sub, err_next;

    logic minor_move, move_x, move_y;
    logic present, advance, last_step;

    line_setup #(.WIDTH(WIDTH)) u_setup (
        .x0     (ex0),
        .y0     (ey0),
        .x1     (ex1),
        .y1     (ey1),
        .sx_neg (set_sx_neg),
        .sy_neg (set_sy_neg),
        .steep  (set_steep),
        .major  (set_major),
        .minor  (set_minor)
    );

    divide_by_two #(.W(DW)) u_half (
        .value ($signed(set_major)),
        .half  (half_major)
    );

`ifdef PIXEL_CLIP_EN
    localparam logic signed [WIDTH-1:0] CLIP_W = WIDTH'(SCREEN_W);
    localparam logic signed [WIDTH-1:0] CLIP_H = WIDTH'(SCREEN_H);

    assign present = !cur_x[WIDTH-1] && (cur_x < CLIP_W) &&
                     !cur_y[WIDTH-1] && (cur_y < CLIP_H);
`else
    assign present = 1'b1;
`endif

    // Hidden pixels step freely; presented ones wait for the writer.
    assign advance   = (state == STEP) && (present ? pix_ready : 1'b1);
    assign last_step = (remain == '0);

    always_comb begin
        err_sub    = err - $signed({1'b0, minor_q});
        minor_move = err_sub[EW-1];
        err_next   = minor_move ? err_sub + $signed({1'b0, major_q}) : err_sub;
        move_x     = !steep_q || minor_move;
        move_y     = steep_q || minor_move;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (line_valid) state_next = SETUP;
            SETUP:   state_next = STEP;
            STEP:    if (advance && last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        line_ready = (state == IDLE);
        busy       = (state != IDLE);
        done       = (state == DONE);
        pix_valid  = (state == STEP) && present;
        pix_last   = (state == STEP) && present && last_step;
    end

    // Step counter counts down from the major length; zero marks the end point.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex0      <= '0;
            ey0      <= '0;
            ex1      <= '0;
            ey1      <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            steep_q  <= 1'b0;
            major_q  <= '0;
            minor_q  <= '0;
            remain   <= '0;
            err      <= '0;
        end else begin
            if (state == IDLE && line_valid) begin
                ex0 <= x0;
                ey0 <= y0;
                ex1 <= x1;
                ey1 <= y1;
            end
            if (state == SETUP) begin
                cur_x    <= $signed(ex0);
                cur_y    <= $signed(ey0);
                sx_neg_q <= set_sx_neg;
                sy_neg_q <= set_sy_neg;
                steep_q  <= set_steep;
                major_q  <= set_major;
                minor_q  <= set_minor;
                remain   <= set_major;
                err      <= $signed({half_major[DW-1], half_major});
            end
            if (advance) begin
                err    <= err_next;
                remain <= remain - DW'(1);
                if (move_x) begin
                    cur_x <= sx_neg_q ? cur_x - WIDTH'(1) : cur_x + WIDTH'(1);
                end
                if (move_y) begin
                    cur_y <= sy_neg_q ? cur_y - WIDTH'(1) : cur_y + WIDTH'(1);
                end
            end
        end
    end

    assign pix_x = cur_x;
    assign pix_y = cur_y;

endmodule

// File: tb/tb_line_step_engine.sv
// Scoreboard bench for line_step_engine: expected pixels are queued when a line
// is driven and popped as the DUT hands pixels over.
module tb_line_step_engine;

    localparam int W = 13;

    logic         clk, rst, line_valid, line_ready;
    logic [W-1:0] x0, y0, x1, y1, pix_x, pix_y;
    logic         pix_valid, pix_ready, pix_last, busy, done;

    typedef struct packed {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic                last;
    } pix_t;

    pix_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int done_cyc = -1;
    int done_count = 0;
    int pix_count = 0;

    line_step_engine #(.WIDTH(W), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_last   (pix_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic pushPix(input int px, input int py, input bit last);
        pix_t p;
        p.x  = W'(px);
        p.y  = W'(py);
        p.last = last;
        exp_q.push_back(p);
    endtask

    // Reference walk straight from the line-drawing rules.
    task automatic modelLine(input int ax0, input int ay0, input int ax1, input int ay1,
                             output int n);
        int dx, dy, sx, sy, adx, ady, major, minor, err, px, py;
        bit steep;
        dx = ax1 - ax0;
        dy = ay1 - ay0;
        sx = (dx < 0) ? -1 : 1;
        sy = (dy < 0) ? -1 : 1;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        steep = ady > adx;
        major = steep ? ady : adx;
        minor = steep ? adx : ady;
        err = major / 2;
        px = ax0;
        py = ay0;
        for (int i = 0; i <= major; i++) begin
            pushPix(px, py, i == major);
            err -= minor;
            if (err < 0) begin
                if (steep) px += sx; else py += sy;
                err += major;
            end
            if (steep) py += sy; else px += sx;
        end
        n = major + 1;
    endtask

    always @(negedge clk) begin
        pix_t e;
        if (!rst) begin
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_pixel", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pix_x", $signed(pix_x), e.x);
                    checkOutput("pix_y", $signed(pix_y), e.y);
                    checkOutput("pix_last", pix_last, e.last);
                end
                checkOutput("busy_with_pixel", busy, 1);
                if (pix_count == 0) first_cyc = cyc;
                if (pix_last) last_cyc = cyc;
                pix_count++;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1);
        @(negedge clk);
        checkOutput("line_ready_idle", line_ready, 1);
        pix_count  = 0;
        first_cyc  = -1;
        last_cyc   = -1;
        x0 = W'(ax0);
        y0 = W'(ay0);
        x1 = W'(ax1);
        y1 = W'(ay1);
        line_valid = 1'b1;
        accept_cyc = cyc;
        @(negedge clk);
        line_valid = 1'b0;
    endtask

    task automatic waitLine(input int start_done, input int n_pix, input int n_stall,
                            input int latency);
        for (int i = 0; i < 300 && done_count == start_done; i++) @(negedge clk);
        if (done_count == start_done) begin
            checkOutput("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            @(negedge clk);
            checkOutput("done_pulses", done_count - start_done, 1);
            checkOutput("pixel_count", pix_count, n_pix);
            checkOutput("queue_drained", exp_q.size(), 0);
            checkOutput("first_latency", first_cyc - accept_cyc, latency);
            checkOutput("pixel_span", last_cyc - first_cyc, n_pix - 1 + n_stall);
            checkOutput("done_after_last", done_cyc - last_cyc, 1);
            checkOutput("line_ready_after", line_ready, 1);
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sd, n, ax0, ay0, ax1, ay1;
        bit found;

        rst = 1'b1;
        line_valid = 1'b0;
        pix_ready = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_line_ready", line_ready, 1);
        checkOutput("rst_pix_valid", pix_valid, 0);
        checkOutput("rst_pix_last", pix_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pix_x", $signed(pix_x), 0);
        checkOutput("rst_pix_y", $signed(pix_y), 0);
        rst = 1'b0;

        // Shallow line; a second line offered mid-walk must be ignored.
        $display("[TB] line (0,0)->(4,2)");
        sd = done_count;
        pushPix(0, 0, 0); pushPix(1, 0, 0); pushPix(2, 1, 0); pushPix(3, 1, 0); pushPix(4, 2, 1);
        applyStimulus(0, 0, 4, 2);
        @(posedge clk); #1;
        checkOutput("line_ready_busy", line_ready, 0);
        line_valid = 1'b1;
        x0 = W'(100); y0 = W'(100); x1 = W'(50); y1 = W'(20);
        @(posedge clk); @(posedge clk); #1;
        line_valid = 1'b0;
        waitLine(sd, 5, 0, 2);

        $display("[TB] line (3,5)->(1,0)");
        sd = done_count;
        pushPix(3, 5, 0); pushPix(3, 4, 0); pushPix(2, 3, 0);
        pushPix(2, 2, 0); pushPix(1, 1, 0); pushPix(1, 0, 1);
        applyStimulus(3, 5, 1, 0);
        waitLine(sd, 6, 0, 2);

        $display("[TB] degenerate (7,7)");
        sd = done_count;
        pushPix(7, 7, 1);
        applyStimulus(7, 7, 7, 7);
        waitLine(sd, 1, 0, 2);

        $display("[TB] backpressure on (2,1)");
        sd = done_count;
        pushPix(0, 0, 0); pushPix(1, 0, 0); pushPix(2, 1, 0); pushPix(3, 1, 0); pushPix(4, 2, 1);
        applyStimulus(0, 0, 4, 2);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (pix_valid && $signed(pix_x) == 2 && $signed(pix_y) == 1) found = 1'b1;
        end
        pix_ready = 1'b0;
        checkOutput("stall_reached", found, 1);
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", pix_valid, 1);
            checkOutput("hold_x", $signed(pix_x), 2);
            checkOutput("hold_y", $signed(pix_y), 1);
            checkOutput("hold_last", pix_last, 0);
        end
        pix_ready = 1'b1;
        waitLine(sd, 5, 3, 2);

        $display("[TB] reset mid-line (0,0)->(10,0)");
        sd = done_count;
        modelLine(0, 0, 10, 0, n);
        applyStimulus(0, 0, 10, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (pix_valid && $signed(pix_x) == 2) found = 1'b1;
        end
        checkOutput("rst_point_reached", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_pix_valid", pix_valid, 0);
        checkOutput("midrst_line_ready", line_ready, 1);
        checkOutput("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrst_no_done", done_count - sd, 0);
        checkOutput("midrst_pixels", pix_count, 2);
        exp_q.delete();

        $display("[TB] random lines");
        for (int k = 0; k < 6; k++) begin
            ax0 = int'($urandom_range(0, 60)) - 30;
            ay0 = int'($urandom_range(0, 60)) - 30;
            ax1 = int'($urandom_range(0, 60)) - 30;
            ay1 = int'($urandom_range(0, 60)) - 30;
            sd = done_count;
            modelLine(ax0, ay0, ax1, ay1, n);
            applyStimulus(ax0, ay0, ax1, ay1);
            waitLine(sd, n, 0, 2);
        end

`ifdef PIXEL_CLIP_EN
        $display("[TB] clipped line (-2,0)->(2,0)");
        sd = done_count;
        pushPix(0, 0, 0); pushPix(1, 0, 0); pushPix(2, 0, 1);
        applyStimulus(-2, 0, 2, 0);
        waitLine(sd, 3, 0, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
